// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module : alu_pkg
// Brief  : Opcode encodings and command record shared by the ALU issue stage.
// Rev    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int ALU_W = 8;

  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_SUB_AB = 3'b001;
  localparam logic [2:0] OP_SUB_BA = 3'b010;
  localparam logic [2:0] OP_OR     = 3'b011;
  localparam logic [2:0] OP_AND    = 3'b100;
  localparam logic [2:0] OP_XOR    = 3'b101;
  localparam logic [2:0] OP_XNOR   = 3'b110;
  localparam logic [2:0] OP_ZERO   = 3'b111;

  typedef struct packed {
    logic [2:0]       oper;
    logic             use_prev;
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module : alu_cmd_fifo
// Brief  : Synchronous command FIFO, registered occupancy, no write-to-read bypass.
// Rev    : 1.0 - initial release
// ============================================================================
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = CMD_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_pop;

  // Pop is gated on the registered level, so an entry written this cycle is
  // never visible to the reader until the following cycle.
  assign w_pop   = i_pop & (r_level != '0);
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule : alu_cmd_fifo
`default_nettype wire

// File: rtl/alu_8bit_issue.sv
`default_nettype none
// ============================================================================
// Module : alu_8bit_issue
// Brief  : Command FIFO -> issue register driving an external ALU -> result reg.
// Rev    : 1.0 - initial release
// ============================================================================
module alu_8bit_issue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_oper,
  input  logic [W-1:0]             cmd_a,
  input  logic [W-1:0]             cmd_b,
  input  logic                     cmd_use_prev,
  output logic [W-1:0]             alu_a,
  output logic [W-1:0]             alu_b,
  output logic [2:0]               alu_oper,
  input  logic [W-1:0]             alu_sum,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [W-1:0]             res_data,
  output logic [2:0]               res_oper,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  cmd_t         w_cmd_in;
  cmd_t         w_head;
  logic         w_empty;
  logic         w_push;
  logic         w_adv1;
  logic         w_adv2;
  logic [W-1:0] w_opa;

  logic         r_s1_valid;
  logic [W-1:0] r_alu_a;
  logic [W-1:0] r_alu_b;
  logic [2:0]   r_alu_oper;
  logic         r_res_valid;
  logic [W-1:0] r_res_data;
  logic [2:0]   r_res_oper;
  logic [W-1:0] r_prev;

  assign w_cmd_in = '{oper: cmd_oper, use_prev: cmd_use_prev, a: cmd_a, b: cmd_b};

  assign cmd_ready = (fifo_level != LVL_W'(DEPTH));
  assign w_push    = cmd_valid & cmd_ready;
  assign w_adv2    = r_s1_valid & (~r_res_valid | res_ready);
  assign w_adv1    = ~w_empty & (~r_s1_valid | w_adv2);

  // An occupied S1 always retires alongside adv1, so its ALU output is the
  // newest result in program order and is forwarded ahead of r_prev.
  assign w_opa = w_head.use_prev ? (r_s1_valid ? alu_sum : r_prev) : w_head.a;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_cmd_in),
    .i_pop   (w_adv1),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_oper <= OP_ZERO;
    end else if (w_adv1) begin
      r_s1_valid <= 1'b1;
      r_alu_a    <= w_opa;
      r_alu_b    <= w_head.b;
      r_alu_oper <= w_head.oper;
    end else if (w_adv2) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_oper  <= '0;
      r_prev      <= '0;
    end else if (w_adv2) begin
      r_res_valid <= 1'b1;
      r_res_data  <= alu_sum;
      r_res_oper  <= r_alu_oper;
      r_prev      <= alu_sum;
    end else if (res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_oper  = r_alu_oper;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_oper  = r_res_oper;

endmodule : alu_8bit_issue
`default_nettype wire

// File: tb/tb_alu_8bit_issue.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_8bit_issue
// Brief  : Directed plus random bench with an in-bench ALU and result model.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu_8bit_issue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_use_prev;
  logic [2:0] cmd_oper;
  logic [7:0] cmd_a, cmd_b;
  logic [7:0] alu_a, alu_b, alu_sum;
  logic [2:0] alu_oper;
  logic       res_valid, res_ready;
  logic [7:0] res_data;
  logic [2:0] res_oper;
  logic [2:0] fifo_level;

  int n_assert = 0;
  int n_fail   = 0;
  int n_results = 0;

  typedef struct {
    logic [2:0] op;
    logic [7:0] d;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] last_res;

  always #5 clk = ~clk;

  alu_8bit_issue #(.DEPTH(4), .W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_oper(cmd_oper),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_prev(cmd_use_prev),
    .alu_a(alu_a), .alu_b(alu_b), .alu_oper(alu_oper), .alu_sum(alu_sum),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_oper(res_oper), .fifo_level(fifo_level)
  );

  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int ia = int'(a);
    int ib = int'(b);
    int r;
    case (op)
      3'd0:    r = ia + ib;
      3'd1:    r = ia - ib;
      3'd2:    r = ib - ia;
      3'd3:    r = ia | ib;
      3'd4:    r = ia & ib;
      3'd5:    r = ia ^ ib;
      3'd6:    r = ~(ia ^ ib);
      default: r = 0;
    endcase
    return 8'(r);
  endfunction

  // The external ALU the issue stage drives.
  always_comb alu_sum = alu_f(alu_oper, alu_a, alu_b);

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Commands complete in order, so "previous result" is simply the result of
  // the command accepted just before this one.
  task automatic model_push(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic up);
    logic [7:0] r;
    r = alu_f(op, up ? last_res : a, b);
    exp_q.push_back('{op: op, d: r});
    last_res = r;
  endtask

  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      n_assert++;
      assert (exp_q.size() != 0)
      else begin
        n_fail++;
        $error("FAIL unexpected_result observed=%0h expected=none", res_data);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        n_results++;
        n_assert++;
        assert (res_data === mon_e.d)
        else begin
          n_fail++;
          $error("FAIL res_data observed=%0h expected=%0h", res_data, mon_e.d);
        end
        n_assert++;
        assert (res_oper === mon_e.op)
        else begin
          n_fail++;
          $error("FAIL res_oper observed=%0h expected=%0h", res_oper, mon_e.op);
        end
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic up);
    bit ok = 1'b0;
    cmd_valid = 1'b1; cmd_oper = op; cmd_a = a; cmd_b = b; cmd_use_prev = up;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 16'(cmd_ready), 16'd1);
    else     model_push(op, a, b, up);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 400; t++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("drain_empty", 16'(exp_q.size()), 16'd0);
    @(posedge clk); #1;
  endtask

  // One command into an idle pipe: result appears exactly two edges after the push edge.
  task automatic single(input string tag, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_res);
    send(op, a, b, 1'b0);
    idle();
    chk({tag, "_n1_valid"}, 16'(res_valid), 16'd0);
    @(posedge clk); #1;
    chk({tag, "_s1_oper"}, 16'(alu_oper), 16'(op));
    chk({tag, "_n1_valid2"}, 16'(res_valid), 16'd0);
    @(posedge clk); #1;
    chk({tag, "_n2_valid"}, 16'(res_valid), 16'd1);
    chk({tag, "_data"}, 16'(res_data), 16'(exp_res));
    chk({tag, "_oper"}, 16'(res_oper), 16'(op));
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_res_valid"}, 16'(res_valid), 16'd0);
    chk({tag, "_res_data"}, 16'(res_data), 16'd0);
    chk({tag, "_res_oper"}, 16'(res_oper), 16'd0);
    chk({tag, "_level"}, 16'(fifo_level), 16'd0);
    chk({tag, "_cmd_ready"}, 16'(cmd_ready), 16'd1);
    chk({tag, "_alu_a"}, 16'(alu_a), 16'd0);
    chk({tag, "_alu_b"}, 16'(alu_b), 16'd0);
    chk({tag, "_alu_oper"}, 16'(alu_oper), 16'd7);
  endtask

  initial begin
    int acc;
    int base;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_oper = '0; cmd_a = '0; cmd_b = '0;
    cmd_use_prev = 1'b0; res_ready = 1'b1; last_res = '0;
    #22;
    chk_reset_state("por");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic add and latency
    single("add", 3'b000, 8'h0F, 8'h01, 8'h10);

    // Subtraction wrap both directions
    single("sub_ab", 3'b001, 8'h05, 8'h07, 8'hFE);
    single("sub_ba", 3'b010, 8'h05, 8'h07, 8'h02);

    // Back-to-back chain through the forwarding path
    send(3'b000, 8'h03, 8'h04, 1'b0);
    send(3'b101, 8'h99, 8'hFF, 1'b1);
    idle();
    @(posedge clk); #1;
    chk("chain_first", 16'(res_data), 16'h07);
    @(posedge clk); #1;
    chk("chain_fwd", 16'(res_data), 16'hF8);
    drain();

    // Backpressure: fill S2 and S1, then offer six commands
    res_ready = 1'b0;
    send(3'b000, 8'h01, 8'h01, 1'b0);
    send(3'b000, 8'h02, 8'h02, 1'b0);
    idle();
    repeat (3) begin @(posedge clk); #1; end
    chk("bp_res_valid", 16'(res_valid), 16'd1);
    chk("bp_level0", 16'(fifo_level), 16'd0);
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1; cmd_oper = 3'(i); cmd_a = 8'($urandom); cmd_b = 8'($urandom);
      cmd_use_prev = (i == 3);
      @(negedge clk);
      if (cmd_ready) begin
        model_push(cmd_oper, cmd_a, cmd_b, cmd_use_prev);
        acc++;
      end
      @(posedge clk); #1;
    end
    idle();
    chk("bp_accepted", 16'(acc), 16'd4);
    chk("bp_cmd_ready", 16'(cmd_ready), 16'd0);
    chk("bp_level", 16'(fifo_level), 16'd4);
    chk("bp_alu_a", 16'(alu_a), 16'h02);
    chk("bp_alu_b", 16'(alu_b), 16'h02);
    chk("bp_alu_oper", 16'(alu_oper), 16'd0);
    chk("bp_res_hold", 16'(res_data), 16'h02);
    base = n_results;
    res_ready = 1'b1;
    drain();
    chk("bp_result_count", 16'(n_results - base), 16'd6);

    // Reset mid-stream with FIFO=3 and a pending result
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(3'b000, 8'(i), 8'h10, 1'b0);
    idle();
    chk("rst_pre_level", 16'(fifo_level), 16'd3);
    chk("rst_pre_valid", 16'(res_valid), 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state("midrst");
    exp_q.delete();
    last_res = '0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", 16'(res_valid), 16'd0);
    single("post_rst_and", 3'b100, 8'hF0, 8'h3C, 8'h30);

    // Logic opcodes and the zero opcode
    single("op_or",   3'b011, 8'hA5, 8'h5A, 8'hFF);
    single("op_xnor", 3'b110, 8'hA5, 8'h5A, 8'h00);
    single("op_zero", 3'b111, 8'hA5, 8'h5A, 8'h00);

    // Random traffic with random backpressure and chaining
    for (int i = 0; i < 300; i++) begin
      res_ready    = ($urandom_range(0, 3) != 0);
      cmd_valid    = ($urandom_range(0, 2) != 0);
      cmd_oper     = 3'($urandom);
      cmd_a        = 8'($urandom);
      cmd_b        = 8'($urandom);
      cmd_use_prev = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      if (cmd_valid && cmd_ready) model_push(cmd_oper, cmd_a, cmd_b, cmd_use_prev);
      @(posedge clk); #1;
    end
    idle();
    res_ready = 1'b1;
    drain();
    chk("final_idle_valid", 16'(res_valid), 16'd0);
    chk("final_level", 16'(fifo_level), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_alu_8bit_issue
`default_nettype wire
